// File: rtl/io_hdx_ctrl.sv
// Half-duplex single-wire command/response controller: UART-style TX frame, bus turnaround, timed RX.
// Define IO_HDX_PARITY_EN to add an even-parity bit to both TX and RX frames.
module io_hdx_ctrl #(
  parameter int CLK_DIV      = 4,
  parameter int TURN_BITS    = 2,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_err,
  output logic       done,
  output logic       pad_o,
  output logic       pad_t,
  input  logic       pad_i
);

`ifdef IO_HDX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // TX shift register holds everything after the start bit (data, parity, stop)
  localparam int TX_W      = 9 + PAR_BITS;
  localparam int FRAME_W   = TX_W + 1;
  localparam int RX_W      = 8 + PAR_BITS;
  localparam int TURN_CYC  = TURN_BITS * CLK_DIV;
  localparam int TO_CYC    = TIMEOUT_BITS * CLK_DIV;
  localparam int FIRST_CYC = CLK_DIV + CLK_DIV / 2;
  localparam int CNT_MAX0  = (TURN_CYC > TO_CYC) ? TURN_CYC : TO_CYC;
  localparam int CNT_MAX   = (CNT_MAX0 > FIRST_CYC) ? CNT_MAX0 : FIRST_CYC;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] BIT_RELOAD   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] TURN_RELOAD  = CNT_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] TO_RELOAD    = CNT_W'(TO_CYC - 1);
  localparam logic [CNT_W-1:0] FIRST_RELOAD = CNT_W'(FIRST_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [3:0]       TX_LAST      = 4'(FRAME_W - 1);
  localparam logic [3:0]       RX_LAST      = 4'(RX_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_TURN,
    S_RX_WAIT,
    S_RX,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [1:0]        sync_q;
  logic [1:0]        listen_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        bit_q;
  logic [TX_W-1:0]   tx_sh_q;
  logic [RX_W-2:0]   rx_sh_q;
  logic              is_read_q;
  logic              tx_ready_q;
  logic              pad_o_q;
  logic              pad_t_q;
  logic              rx_valid_q;
  logic              done_q;
  logic [7:0]        rx_data_q;
  logic              rx_err_q;

  logic              pad_s;
  logic              start_seen;
  logic [TX_W-1:0]   tx_frame_d;
  logic [RX_W-1:0]   rx_sh_d;
  logic              rx_err_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      listen_q <= 2'b00;
    end else begin
      sync_q   <= {sync_q[0], pad_i};
      // Tags each synchronizer stage with whether it was sampled while listening,
      // so pad activity captured during TX/TURN can never look like a start bit.
      listen_q <= {listen_q[0], (state_q == S_RX_WAIT) || (state_q == S_RX)};
    end
  end

  assign pad_s      = sync_q[1];
  assign start_seen = !pad_s && listen_q[1];

  always_comb begin
    rx_sh_d = {pad_s, rx_sh_q};
`ifdef IO_HDX_PARITY_EN
    tx_frame_d = {1'b1, ^tx_data, tx_data};
    rx_err_d   = rx_sh_d[RX_W-1] ^ (^rx_sh_d[7:0]);
`else
    tx_frame_d = {1'b1, tx_data};
    rx_err_d   = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= 4'd0;
      tx_sh_q    <= '1;
      rx_sh_q    <= '0;
      is_read_q  <= 1'b0;
      tx_ready_q <= 1'b1;
      pad_o_q    <= 1'b1;
      pad_t_q    <= 1'b1;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_err_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          pad_o_q <= 1'b1;
          pad_t_q <= 1'b1;
          if (tx_valid) begin
            state_q    <= S_TX;
            tx_ready_q <= 1'b0;
            is_read_q  <= tx_data[7];
            tx_sh_q    <= tx_frame_d;
            pad_o_q    <= 1'b0;
            cnt_q      <= BIT_RELOAD;
            bit_q      <= 4'd0;
          end
        end

        S_TX: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else if (bit_q != TX_LAST) begin
            bit_q   <= bit_q + 4'd1;
            pad_o_q <= tx_sh_q[0];
            tx_sh_q <= {1'b1, tx_sh_q[TX_W-1:1]};
            cnt_q   <= BIT_RELOAD;
          end else if (is_read_q) begin
            state_q <= S_TURN;
            pad_t_q <= 1'b0;
            cnt_q   <= TURN_RELOAD;
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end

        S_TURN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            state_q <= S_RX_WAIT;
            cnt_q   <= TO_RELOAD;
          end
        end

        S_RX_WAIT: begin
          if (start_seen) begin
            state_q <= S_RX;
            cnt_q   <= FIRST_RELOAD;
            bit_q   <= 4'd0;
          end else if (cnt_q == '0) begin
            state_q    <= S_DONE;
            done_q     <= 1'b1;
            rx_valid_q <= 1'b1;
            rx_data_q  <= 8'h00;
            rx_err_q   <= 1'b1;
            pad_t_q    <= 1'b1;
            pad_o_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        S_RX: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            rx_sh_q <= rx_sh_d[RX_W-1:1];
            if (bit_q != RX_LAST) begin
              bit_q <= bit_q + 4'd1;
              cnt_q <= BIT_RELOAD;
            end else begin
              // Stop bit is not checked; the result is delivered on the last data/parity sample.
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              rx_valid_q <= 1'b1;
              rx_data_q  <= rx_sh_d[7:0];
              rx_err_q   <= rx_err_d;
              pad_t_q    <= 1'b1;
              pad_o_q    <= 1'b1;
            end
          end
        end

        S_DONE: begin
          state_q    <= S_IDLE;
          tx_ready_q <= 1'b1;
          pad_t_q    <= 1'b1;
          pad_o_q    <= 1'b1;
        end

        default: begin
          state_q    <= S_IDLE;
          tx_ready_q <= 1'b1;
          pad_t_q    <= 1'b1;
          pad_o_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign rx_err   = rx_err_q;
  assign done     = done_q;
  assign pad_o    = pad_o_q;
  assign pad_t    = pad_t_q;

endmodule

// File: tb/tb_io_hdx_ctrl.sv
// Randomized bench for io_hdx_ctrl: a remote-device model answers reads on the shared pad,
// and expected frames/timing are derived from the protocol rules.
module tb_io_hdx_ctrl;
  localparam int DIV  = 4;
  localparam int TURN = 2;
  localparam int TOB  = 16;
`ifdef IO_HDX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = 10 + PAR;
  localparam int NRX   = 8 + PAR;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, rx_valid, rx_err, done, pad_o, pad_t, pad_i;
  logic [7:0] rx_data;

  logic        rem_line = 1'b1;
  logic        glitch_now = 1'b0;
  bit          rem_on = 1'b0;
  int          rem_x = -1000;
  logic [15:0] rem_bits = '1;
  int          glitch_cyc = -1;
  int          cyc = 0;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  last_rx_data = 8'h00;
  logic        last_rx_err = 1'b0;
  int          last_done = 0;

  io_hdx_ctrl #(.CLK_DIV(DIV), .TURN_BITS(TURN), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err), .done(done),
    .pad_o(pad_o), .pad_t(pad_t), .pad_i(pad_i)
  );

  // Shared wire: the pad reads back its own drive when enabled, otherwise the remote (pulled high).
  assign pad_i = (pad_t ? pad_o : rem_line) & ~glitch_now;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rem_on && cyc >= rem_x && cyc < rem_x + (NRX + 2) * DIV)
      rem_line <= rem_bits[(cyc - rem_x) / DIV];
    else
      rem_line <= 1'b1;
    glitch_now <= (cyc == glitch_cyc);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic frame_bit(input logic [7:0] cmd, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return cmd[i-1];
    if (PAR == 1 && i == 9) return logic'($countones(cmd) % 2);
    return 1'b1;
  endfunction

  task automatic run_txn(input logic [7:0] cmd, input bit reply, input int d, input logic [7:0] rdata,
                         input bit pflip, input bit glitch, input bit hold, input logic [7:0] next_cmd,
                         input bit b2b);
    int h, w, exp_done, n;
    logic [7:0] exp_data;
    logic exp_err;
    bit is_read;
    is_read = cmd[7];
    chk("ready_before", tx_ready, 1);
    tx_valid = 1'b1;
    tx_data  = cmd;
    tick();
    h = cyc;
    if (b2b) chk("b2b_start", h, last_done + 2);
    if (hold) tx_data = next_cmd;
    else begin
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
    end
    w = h + FRAME * DIV + TURN * DIV;
    rem_on = 1'b0;
    if (is_read && reply) begin
      rem_bits = '1;
      rem_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) rem_bits[1 + i] = rdata[i];
      if (PAR == 1) rem_bits[9] = logic'($countones(rdata) % 2) ^ pflip;
      rem_x  = w + d;
      rem_on = 1'b1;
    end
    glitch_cyc = glitch ? h + $urandom_range(0, FRAME * DIV + (is_read ? TURN * DIV : 0) - 1) : -1;

    for (int c = 0; c < FRAME * DIV; c++) begin
      chk("tx_pad_t", pad_t, 1);
      chk("tx_pad_o", pad_o, frame_bit(cmd, c / DIV));
      chk("tx_ready_busy", tx_ready, 0);
      chk("tx_done", done, 0);
      if (!hold) begin
        tx_valid = 1'($urandom_range(0, 1));
        tx_data  = 8'($urandom);
      end
      tick();
    end
    if (!hold) tx_valid = 1'b0;

    if (!is_read) begin
      chk("wr_done", done, 1);
      chk("wr_rx_valid", rx_valid, 0);
      chk("wr_pad_t", pad_t, 1);
      chk("wr_pad_o", pad_o, 1);
      chk("wr_rx_data_hold", rx_data, last_rx_data);
      last_done = cyc;
    end else begin
      for (int c = 0; c < TURN * DIV; c++) begin
        chk("turn_pad_t", pad_t, 0);
        chk("turn_done", done, 0);
        tx_valid = 1'($urandom_range(0, 1));
        tick();
      end
      tx_valid = 1'b0;
      // Start is seen two synchronizer stages plus one decision edge after the remote drives it.
      if (reply && d + 3 <= TOB * DIV) begin
        exp_done = w + d + 3 + DIV + DIV / 2 + (NRX - 1) * DIV;
        exp_data = rdata;
        exp_err  = (PAR == 1) ? pflip : 1'b0;
      end else begin
        exp_done = w + TOB * DIV;
        exp_data = 8'h00;
        exp_err  = 1'b1;
      end
      n = 0;
      while (done !== 1'b1 && n < 400) begin
        chk("rxw_pad_t", pad_t, 0);
        chk("rxw_rx_valid", rx_valid, 0);
        tick();
        n++;
      end
      chk("rd_done_cycle", (done === 1'b1) ? cyc : -1, exp_done);
      chk("rd_rx_valid", rx_valid, 1);
      chk("rd_rx_data", rx_data, exp_data);
      chk("rd_rx_err", rx_err, exp_err);
      chk("rd_pad_t", pad_t, 1);
      chk("rd_pad_o", pad_o, 1);
      last_rx_data = exp_data;
      last_rx_err  = exp_err;
      last_done    = cyc;
    end
    $display("txn cmd=0x%02h read=%0d reply=%0d d=%0d rdata=0x%02h pflip=%0d glitch=%0d",
             cmd, is_read, reply, d, rdata, pflip, glitch);
    tick();
    chk("idle_ready", tx_ready, 1);
    chk("idle_done", done, 0);
    chk("idle_rx_valid", rx_valid, 0);
    chk("idle_pad_t", pad_t, 1);
    chk("idle_pad_o", pad_o, 1);
    chk("hold_rx_data", rx_data, last_rx_data);
    chk("hold_rx_err", rx_err, last_rx_err);
  endtask

  initial begin
    int r, d;
    bit reply, pflip;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_ready", tx_ready, 1);
    chk("rst_pad_t", pad_t, 1);
    chk("rst_pad_o", pad_o, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_err", rx_err, 0);
    rst_n = 1'b1;
    tick();

    run_txn(8'h35, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
    run_txn(8'hA5, 1, 2, 8'h3C, 0, 0, 0, 8'h00, 0);
    run_txn(8'h80, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
`ifdef IO_HDX_PARITY_EN
    run_txn(8'hA5, 1, 2, 8'h3C, 1, 0, 0, 8'h00, 0);
`endif

    // Reset in the middle of a write: no done, outputs park immediately.
    rem_on = 1'b0;
    glitch_cyc = -1;
    tx_valid = 1'b1;
    tx_data  = 8'h35;
    tick();
    tx_valid = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_pad_t", pad_t, 1);
    chk("midrst_pad_o", pad_o, 1);
    chk("midrst_ready", tx_ready, 1);
    chk("midrst_done", done, 0);
    chk("midrst_rx_valid", rx_valid, 0);
    chk("midrst_rx_data", rx_data, 0);
    chk("midrst_rx_err", rx_err, 0);
    last_rx_data = 8'h00;
    last_rx_err  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("postrst_done", done, 0);
      chk("postrst_pad_o", pad_o, 1);
    end
    $display("txn reset mid-TX of 0x35");

    run_txn(8'h11, 0, 0, 8'h00, 0, 0, 1, 8'h22, 0);
    run_txn(8'h22, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1);

    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      reply = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 9);
      d = (r < 8) ? $urandom_range(0, 61) : $urandom_range(55, 75);
      pflip = (PAR == 1) && ($urandom_range(0, 3) == 0);
      run_txn(8'($urandom), reply, d, 8'($urandom), pflip, 1'($urandom_range(0, 1)), 0, 8'h00, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
